// File: rtl/mmio_input_ctrl.sv
`default_nettype none
// ============================================================================
// mmio_input_ctrl : synchronised, debounced input bank with sticky rising-edge
//                   flags, per-channel mask, W1C clear and a level irq.
// Revision        : 1.0
// ============================================================================
module mmio_input_ctrl #(
  parameter int CHANNELS        = 24,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] button_in,
  input  logic                sel,
  input  logic                rd,
  input  logic                wr,
  input  logic [1:0]          addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                rdata_valid,
  output logic                irq
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_STATE  = 2'd0;
  localparam logic [1:0] ADDR_EDGE   = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  logic [CHANNELS-1:0] s1_q, s1_d;
  logic [CHANNELS-1:0] s2_q, s2_d;
  logic [CHANNELS-1:0] stable_q, stable_d;
  logic [CHANNELS-1:0] edge_flag_q, edge_flag_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [31:0]         rdata_q, rdata_d;
  logic                rdata_valid_q, rdata_valid_d;

  logic [CHANNELS-1:0] rise;
  logic [31:0]         rd_word;
  logic                wr_en;
  logic                rd_en;
  logic                unused_wdata;

  // Bits of wdata above CHANNELS are architecturally ignored.
  assign unused_wdata = ^wdata;

  assign wr_en = sel & wr;
  assign rd_en = sel & rd;
  assign irq   = |(edge_flag_q & mask_q);

  always_comb begin
    s1_d     = button_in;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    // A rise arriving on the same edge as a W1C clear wins.
    rise        = stable_d & ~stable_q & mask_q;
    edge_flag_d = edge_flag_q | rise;
    if (wr_en && (addr == ADDR_EDGE)) begin
      edge_flag_d = (edge_flag_q & ~wdata[CHANNELS-1:0]) | rise;
    end

    mask_d = mask_q;
    if (wr_en && (addr == ADDR_MASK)) begin
      mask_d = wdata[CHANNELS-1:0];
    end

    rd_word = '0;
    case (addr)
      ADDR_STATE:  rd_word[CHANNELS-1:0] = stable_q;
      ADDR_EDGE:   rd_word[CHANNELS-1:0] = edge_flag_q;
      ADDR_MASK:   rd_word[CHANNELS-1:0] = mask_q;
      ADDR_STATUS: begin
        rd_word[0]    = irq;
        rd_word[15:8] = 8'(CHANNELS);
      end
      default:     rd_word = '0;
    endcase

    rdata_d       = rd_en ? rd_word : rdata_q;
    rdata_valid_d = rd_en;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q          <= '0;
      s2_q          <= '0;
      stable_q      <= '0;
      edge_flag_q   <= '0;
      mask_q        <= '1;
      cnt_q         <= '{default: '0};
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      stable_q      <= stable_d;
      edge_flag_q   <= edge_flag_d;
      mask_q        <= mask_d;
      cnt_q         <= cnt_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule
`default_nettype wire
